// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead byte FIFO and serialises each entry as an asynchronous UART frame:
// start bit, LSB-first data, optional parity, one or two stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic [15:0]           bytes_sent
);

    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int BW        = $clog2(STOP_CLKS);
    localparam int CW        = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_CLKS - 1);
    localparam logic [CW-1:0] IDX_LAST  = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state, w_state_next;
    logic [BW-1:0]         r_baud, w_baud_next;
    logic [CW-1:0]         r_bit, w_bit_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic                  r_parity, w_parity_next;
    logic                  r_tx, w_tx_next;
    logic                  r_busy;
    logic [15:0]           r_count;
    logic                  w_bit_end;
    logic                  w_stop_end;

    assign w_bit_end  = (r_baud == BIT_LAST);
    assign w_stop_end = (r_state == S_STOP) && (r_baud == STOP_LAST);

    // The only pop source; held off during reset so the FIFO never loses a word to it.
    assign fifo_rd_en = (r_state == S_IDLE) && tx_enable && !fifo_empty && !reset;
    assign tx_done    = w_stop_end && !reset;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign bytes_sent = r_count;

    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud + BW'(1);
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_next     = r_tx;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_tx_next   = 1'b1;
                if (fifo_rd_en) begin
                    w_shift_next  = fifo_rd_data;
                    w_parity_next = (PARITY == 2) ? ~^fifo_rd_data : ^fifo_rd_data;
                    w_bit_next    = '0;
                    w_tx_next     = 1'b0;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_tx_next    = r_shift[0];
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit == IDX_LAST) begin
                        if (PARITY != 0) begin
                            w_tx_next    = r_parity;
                            w_state_next = S_PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_bit_next   = r_bit + CW'(1);
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = w_shift_next[0];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_stop_end) begin
                    w_baud_next  = '0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_baud_next  = '0;
                w_tx_next    = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_busy   <= (w_state_next != S_IDLE);
            if (w_stop_end) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: four instances (no parity, even, odd, two stop bits)
// share one FIFO model; a negedge monitor rebuilds each frame and checks it against the queue.
module tb_fifo_uart_tx;

    typedef struct {
        logic [7:0]  data;
        logic        pbit;
        logic [15:0] cnt;
    } item_t;

    logic        clk = 1'b0;
    logic [3:0]  rst_v;
    logic [3:0]  en_v;
    logic [3:0]  empty_v;
    logic [3:0]  rd_en_v;
    logic [3:0]  tx_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [15:0] cnt_a [4];
    logic [7:0]  rd_data;
    logic [7:0]  fmem [16];
    int          wp;
    int          rp;
    int          sel;
    int          n_cmp;
    int          n_err;
    int          pops;
    item_t       exp_q [$];

    // monitor state
    bit          inframe;
    bit          post;
    int          cyc;
    int          done_cnt;
    int          done_at;
    logic        busy_ok;
    logic [47:0] line;
    item_t       cur;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        fifo_uart_tx #(
            .CLKS_PER_BIT(4),
            .DATA_WIDTH  (8),
            .PARITY      (gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
            .STOP_BITS   (gi == 3 ? 2 : 1)
        ) u_dut (
            .clk         (clk),
            .reset       (rst_v[gi]),
            .tx_enable   (en_v[gi]),
            .fifo_empty  (empty_v[gi]),
            .fifo_rd_data(rd_data),
            .fifo_rd_en  (rd_en_v[gi]),
            .tx          (tx_v[gi]),
            .busy        (busy_v[gi]),
            .tx_done     (done_v[gi]),
            .bytes_sent  (cnt_a[gi])
        );
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            empty_v[k] = (sel != k) || (wp == rp);
        end
    end
    assign rd_data = fmem[rp[3:0]];

    always @(posedge clk) begin
        if (rd_en_v[sel]) rp <= rp + 1;
    end

    function automatic int par_of(int s);
        return (s == 1) ? 1 : ((s == 2) ? 2 : 0);
    endfunction

    function automatic int fl_of(int s);
        return (1 + 8 + ((par_of(s) != 0) ? 1 : 0) + ((s == 3) ? 2 : 1)) * 4;
    endfunction

    function automatic logic [47:0] exp_line(item_t it, int s);
        logic [47:0] v;
        int b;
        v = '0;
        for (int k = 0; k < fl_of(s); k++) begin
            b = k / 4;
            if (b == 0)                          v[k] = 1'b0;
            else if (b <= 8)                     v[k] = it.data[b-1];
            else if (b == 9 && par_of(s) != 0)   v[k] = it.pbit;
            else                                 v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Negedge monitor: pop legality on every instance, frame capture on the selected one.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rd_en_v[k]) begin
                pops++;
                check($sformatf("pop legal dut%0d", k), {62'd0, empty_v[k], rst_v[k]}, 64'd0);
            end
        end
        if (rst_v[sel]) begin
            inframe = 1'b0;
            post    = 1'b0;
        end else begin
            if (post) begin
                post = 1'b0;
                check("idle gap tx", {63'd0, tx_v[sel]}, 64'd1);
                check("idle gap busy", {63'd0, busy_v[sel]}, 64'd0);
                check("bytes_sent", {48'd0, cnt_a[sel]}, {48'd0, cur.cnt});
            end
            if (!inframe && tx_v[sel] == 1'b0) begin
                inframe  = 1'b1;
                cyc      = 0;
                line     = '0;
                done_cnt = 0;
                done_at  = -1;
                busy_ok  = 1'b1;
            end
            if (inframe) begin
                line[cyc] = tx_v[sel];
                if (!busy_v[sel]) busy_ok = 1'b0;
                if (done_v[sel]) begin
                    done_cnt++;
                    done_at = cyc;
                end
                cyc++;
                if (cyc == fl_of(sel)) begin
                    inframe = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected frame: dut%0d sent 0x%0h, expected no frame", sel, line);
                    end else begin
                        cur = exp_q.pop_front();
                        $display("frame dut%0d byte 0x%02h len %0d expect cnt %0d", sel, cur.data, cyc, cur.cnt);
                        check("frame bits", {16'd0, line}, {16'd0, exp_line(cur, sel)});
                        check("tx_done pulses", 64'(done_cnt), 64'd1);
                        check("tx_done cycle", 64'(done_at), 64'(fl_of(sel) - 1));
                        check("busy in frame", {63'd0, busy_ok}, 64'd1);
                        post = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push(logic [7:0] b, logic pbit, logic [15:0] cnt, bit expect_frame);
        item_t it;
        fmem[wp[3:0]] = b;
        wp++;
        if (expect_frame) begin
            it.data = b;
            it.pbit = pbit;
            it.cnt  = cnt;
            exp_q.push_back(it);
        end
    endtask

    task automatic wait_idle(string name, int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wp != rp || busy_v[sel]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy(bit level, int budget);
        int n;
        n = 0;
        while (busy_v[sel] != level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy wait", {63'd0, busy_v[sel]}, {63'd0, level});
    endtask

    task automatic drive_slot;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst_v = 4'hF;
        en_v  = 4'h0;
        sel   = 0;
        wp    = 0;
        rp    = 0;
        n_cmp = 0;
        n_err = 0;
        pops  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx", {60'd0, tx_v}, 64'hF);
        check("reset busy", {60'd0, busy_v}, 64'h0);
        check("reset tx_done", {60'd0, done_v}, 64'h0);
        check("reset bytes_sent", {48'd0, cnt_a[0]}, 64'd0);
        drive_slot();
        rst_v = 4'h0;

        // 1: single 0xA5, no parity
        p0 = pops;
        push(8'hA5, 1'b0, 16'd1, 1'b1);
        en_v[0] = 1'b1;
        wait_idle("t1 drain", 200);
        check("t1 pops", 64'(pops - p0), 64'd1);

        // 2: three back-to-back bytes
        drive_slot();
        p0 = pops;
        push(8'h01, 1'b0, 16'd2, 1'b1);
        push(8'h02, 1'b0, 16'd3, 1'b1);
        push(8'h03, 1'b0, 16'd4, 1'b1);
        wait_idle("t2 drain", 400);
        check("t2 pops", 64'(pops - p0), 64'd3);
        check("t2 rd_en when empty", {63'd0, rd_en_v[0]}, 64'd0);

        // 4: tx_enable dropped mid-frame
        drive_slot();
        p0 = pops;
        push(8'h3C, 1'b0, 16'd5, 1'b1);
        push(8'hC3, 1'b0, 16'd6, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        en_v[0] = 1'b0;
        wait_busy(1'b0, 100);
        repeat (10) @(negedge clk);
        check("t4 held pops", 64'(pops - p0), 64'd1);
        check("t4 held busy", {63'd0, busy_v[0]}, 64'd0);
        check("t4 held rd_en", {63'd0, rd_en_v[0]}, 64'd0);
        drive_slot();
        en_v[0] = 1'b1;
        wait_idle("t4 drain", 200);
        check("t4 pops", 64'(pops - p0), 64'd2);

        // 5: reset during DATA; 0x55 is lost, 0x66 follows
        drive_slot();
        p0 = pops;
        push(8'h55, 1'b0, 16'd0, 1'b0);
        push(8'h66, 1'b0, 16'd1, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        drive_slot();
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("t5 tx after reset", {63'd0, tx_v[0]}, 64'd1);
        check("t5 busy after reset", {63'd0, busy_v[0]}, 64'd0);
        check("t5 count after reset", {48'd0, cnt_a[0]}, 64'd0);
        wait_idle("t5 drain", 200);
        check("t5 pops", 64'(pops - p0), 64'd2);

        // 3: even then odd parity on 0x07
        drive_slot();
        sel     = 1;
        en_v[1] = 1'b1;
        push(8'h07, 1'b1, 16'd1, 1'b1);
        wait_idle("t3 even drain", 200);
        drive_slot();
        sel     = 2;
        en_v[2] = 1'b1;
        push(8'h07, 1'b0, 16'd1, 1'b1);
        wait_idle("t3 odd drain", 200);

        // 6: two stop bits
        drive_slot();
        sel     = 3;
        en_v[3] = 1'b1;
        push(8'hE1, 1'b0, 16'd1, 1'b1);
        wait_idle("t6 drain", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
